// File: rtl/encrypted_lock_ctrl.sv
// Lock sequencer: qualifies submit edges against the upstream code-match bit,
// opens a timed unlock window, and enforces a timed lockout after repeated failures.
module encrypted_lock_ctrl #(
    parameter int MAX_FAIL       = 3,
    parameter int UNLOCK_CYCLES  = 16,
    parameter int LOCKOUT_CYCLES = 64,
    parameter int TMR_W          = 8,
    parameter int FAIL_W         = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              match,
    input  logic              submit,
    input  logic              relock,
    input  logic              admin_clear,
    output logic              unlocked,
    output logic              lockout,
    output logic              alarm,
    output logic [FAIL_W-1:0] fail_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OPEN    = 2'd1,
        LOCKOUT = 2'd2
    } state_t;

    localparam logic [TMR_W-1:0]  UNLOCK_LOAD  = TMR_W'(UNLOCK_CYCLES);
    localparam logic [TMR_W-1:0]  LOCKOUT_LOAD = TMR_W'(LOCKOUT_CYCLES);
    localparam logic [FAIL_W:0]   FAIL_LIMIT   = (FAIL_W + 1)'(MAX_FAIL);
    localparam logic [FAIL_W-1:0] FAIL_SAT     = FAIL_W'(MAX_FAIL);

    state_t            state, state_d;
    logic [TMR_W-1:0]  timer, timer_d;
    logic [FAIL_W-1:0] fail_d;
    logic [FAIL_W:0]   fail_inc;
    logic              submit_q;
    logic              attempt;

    assign attempt  = submit & ~submit_q;
    // One extra bit so the compare against MAX_FAIL cannot wrap.
    assign fail_inc = {1'b0, fail_count} + (FAIL_W + 1)'(1);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d = state;
        timer_d = timer;
        fail_d  = fail_count;

        unique case (state)
            IDLE: begin
                if (admin_clear) begin
                    fail_d = '0;
                end else if (attempt) begin
                    if (match) begin
                        state_d = OPEN;
                        timer_d = UNLOCK_LOAD;
                        fail_d  = '0;
                    end else if (fail_inc >= FAIL_LIMIT) begin
                        state_d = LOCKOUT;
                        timer_d = LOCKOUT_LOAD;
                        fail_d  = FAIL_SAT;
                    end else begin
                        fail_d = fail_inc[FAIL_W-1:0];
                    end
                end
            end

            OPEN: begin
                // Attempts are deliberately ignored while the window is open.
                if (admin_clear) begin
                    fail_d = '0;
                end
                if (relock || timer <= TMR_W'(1)) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer - TMR_W'(1);
                end
            end

            LOCKOUT: begin
                if (admin_clear || timer <= TMR_W'(1)) begin
                    state_d = IDLE;
                    timer_d = '0;
                    fail_d  = '0;
                end else begin
                    timer_d = timer - TMR_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                timer_d = '0;
                fail_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (rst) begin
            state      <= IDLE;
            timer      <= '0;
            fail_count <= '0;
            submit_q   <= 1'b0;
            unlocked   <= 1'b0;
            lockout    <= 1'b0;
            alarm      <= 1'b0;
        end else begin
            state      <= state_d;
            timer      <= timer_d;
            fail_count <= fail_d;
            submit_q   <= submit;
            unlocked   <= (state_d == OPEN);
            lockout    <= (state_d == LOCKOUT);
            alarm      <= (state_d == LOCKOUT) && (state != LOCKOUT);
        end
    end

endmodule

// File: tb/tb_encrypted_lock_ctrl.sv
// Directed bench for encrypted_lock_ctrl with default parameters
// (MAX_FAIL=3, UNLOCK_CYCLES=16, LOCKOUT_CYCLES=64).
module tb_encrypted_lock_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       match = 1'b0;
    logic       submit = 1'b0;
    logic       relock = 1'b0;
    logic       admin_clear = 1'b0;
    logic       unlocked;
    logic       lockout;
    logic       alarm;
    logic [1:0] fail_count;

    int total = 0;
    int bad   = 0;
    int cnt;
    int alarm_cnt;

    encrypted_lock_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .match       (match),
        .submit      (submit),
        .relock      (relock),
        .admin_clear (admin_clear),
        .unlocked    (unlocked),
        .lockout     (lockout),
        .alarm       (alarm),
        .fail_count  (fail_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle; outputs are read 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        check("never_both", int'(unlocked & lockout), 0);
    endtask

    // One attempt: a low cycle so submit_q clears, then a rising edge of submit.
    task automatic pulse(input logic m);
        submit = 1'b0;
        tick();
        submit = 1'b1;
        match  = m;
        tick();
        submit = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_unl"},  int'(unlocked),   0);
        check({tag, "_lock"}, int'(lockout),    0);
        check({tag, "_alm"},  int'(alarm),      0);
        check({tag, "_fc"},   int'(fail_count), 0);
    endtask

    initial begin
        // 1: reset, then a good attempt opens for exactly 16 cycles
        tick();
        tick();
        check_zero("reset");
        rst = 1'b0;
        pulse(1'b1);
        check("t1_open", int'(unlocked), 1);
        check("t1_fc", int'(fail_count), 0);
        cnt = 0;
        while (unlocked && cnt < 100) begin
            cnt++;
            tick();
        end
        check("t1_open_len", cnt, 16);

        // 2: three failures -> lockout for 64 cycles with one alarm pulse
        pulse(1'b0);
        check("t2_fc1", int'(fail_count), 1);
        pulse(1'b0);
        check("t2_fc2", int'(fail_count), 2);
        check("t2_nolock", int'(lockout), 0);
        pulse(1'b0);
        check("t2_lock", int'(lockout), 1);
        check("t2_alarm", int'(alarm), 1);
        check("t2_fc_sat", int'(fail_count), 3);
        cnt = 0;
        alarm_cnt = 0;
        while (lockout && cnt < 200) begin
            alarm_cnt += int'(alarm);
            cnt++;
            tick();
        end
        check("t2_lock_len", cnt, 64);
        check("t2_alarm_cnt", alarm_cnt, 1);
        check("t2_fc_after", int'(fail_count), 0);

        // 3: two failures then success clears the count, no alarm
        pulse(1'b0);
        check("t3_fc1", int'(fail_count), 1);
        pulse(1'b0);
        check("t3_fc2", int'(fail_count), 2);
        pulse(1'b1);
        check("t3_open", int'(unlocked), 1);
        check("t3_fc0", int'(fail_count), 0);
        check("t3_noalarm", int'(alarm), 0);

        // 5a: attempt during OPEN ignored, relock at window cycle 5 closes it
        pulse(1'b0);
        check("t5_open_ign_fc", int'(fail_count), 0);
        check("t5_open_still", int'(unlocked), 1);
        tick();
        tick();
        check("t5_pre_relock", int'(unlocked), 1);
        relock = 1'b1;
        tick();
        relock = 1'b0;
        check("t5_relocked", int'(unlocked), 0);

        // 4: submit held for 10 cycles counts once
        submit = 1'b1;
        match  = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("t4_held_fc", int'(fail_count), 1);
        pulse(1'b0);
        check("t4_fc2", int'(fail_count), 2);
        pulse(1'b0);
        check("t4_lock", int'(lockout), 1);
        pulse(1'b1);
        check("t4_lock_nounl", int'(unlocked), 0);
        check("t4_lock_stays", int'(lockout), 1);
        check("t4_lock_fc", int'(fail_count), 3);

        // 5b: admin_clear at lockout cycle 10 drops lockout next edge
        for (int i = 0; i < 7; i++) tick();
        check("t5_pre_clear", int'(lockout), 1);
        admin_clear = 1'b1;
        tick();
        admin_clear = 1'b0;
        check("t5_cleared", int'(lockout), 0);
        check("t5_cleared_fc", int'(fail_count), 0);
        check("t5_cleared_alm", int'(alarm), 0);

        // 6: reset mid-OPEN and mid-LOCKOUT; submit held through release
        pulse(1'b1);
        tick();
        tick();
        check("t6_open", int'(unlocked), 1);
        rst = 1'b1;
        tick();
        check_zero("t6_rst_open");
        rst = 1'b0;
        pulse(1'b0);
        pulse(1'b0);
        pulse(1'b0);
        tick();
        tick();
        check("t6_lock", int'(lockout), 1);
        rst    = 1'b1;
        submit = 1'b1;
        match  = 1'b0;
        tick();
        check_zero("t6_rst_lock");
        tick();
        rst = 1'b0;
        tick();
        check("t6_held_edge", int'(fail_count), 1);
        tick();
        tick();
        tick();
        check("t6_held_once", int'(fail_count), 1);
        submit = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/encrypted_lock_ctrl.md
Name: encrypted_lock_ctrl

Overview:
- Sequential controller directly downstream of the combinational code-match stage; consumes its one-bit match result.
- Qualifies each user attempt on a rising edge of `submit`, then drives a timed unlock window.
- Counts consecutive failed attempts and enters a timed lockout with an alarm pulse after MAX_FAIL failures.
- Supports an early relock and an administrative clear.

Parameters:
- MAX_FAIL, 3: consecutive failed attempts that trigger lockout; legal range 1..2^FAIL_W-1.
- UNLOCK_CYCLES, 16: cycles `unlocked` stays high per successful attempt; must be ≥1.
- LOCKOUT_CYCLES, 64: cycles `lockout` stays high; must be ≥1.
- TMR_W, 8: timer width; must hold max(UNLOCK_CYCLES, LOCKOUT_CYCLES).
- FAIL_W, 2: width of `fail_count`.

Ports:
- clk, input, 1: single clock, all logic on rising edge.
- rst, input, 1: synchronous, active-high reset.
- match, input, 1: code-match result from upstream combinational stage; sampled only on an attempt.
- submit, input, 1: user "enter" level; an attempt is its rising edge.
- relock, input, 1: forces early return from OPEN to IDLE.
- admin_clear, input, 1: clears lockout and fail count.
- unlocked, output, 1: registered; high while state is OPEN.
- lockout, output, 1: registered; high while state is LOCKOUT.
- alarm, output, 1: registered one-cycle pulse on entry to LOCKOUT.
- fail_count, output, FAIL_W: registered count of consecutive failed attempts.

Behaviour:
- Reset (rst=1 at a clock edge) sets:
  - state=IDLE, timer=0, fail_count=0, unlocked=0, lockout=0, alarm=0.
  - submit_q=0, so a `submit` already high when reset releases counts as an edge.
- Attempt detection: `attempt = submit & ~submit_q`; submit_q is registered every cycle. Holding `submit` high yields exactly one attempt.
- Priority on each edge: rst > admin_clear > relock > attempt/timer.
- IDLE:
  - attempt & match:
    - next state OPEN; timer=UNLOCK_CYCLES.
    - fail_count=0.
    - unlocked=1 from the following cycle.
  - attempt & ~match & fail_count+1 < MAX_FAIL: fail_count increments; state stays IDLE.
  - attempt & ~match & fail_count+1 == MAX_FAIL:
    - next state LOCKOUT; timer=LOCKOUT_CYCLES.
    - fail_count=MAX_FAIL (saturates).
    - alarm=1 for exactly one cycle, coincident with the first lockout=1 cycle.
- OPEN:
  - Timer decrements each cycle. When timer==1, next state is IDLE, so `unlocked` is high exactly UNLOCK_CYCLES cycles.
  - Attempts are ignored: no count change, no window restart.
  - relock=1 forces IDLE on the next edge.
- LOCKOUT:
  - Timer decrements; all attempts are ignored and `match` is don't-care.
  - When timer==1, next state is IDLE with fail_count=0, so `lockout` is high exactly LOCKOUT_CYCLES cycles.
  - admin_clear=1 forces IDLE and fail_count=0 on the next edge. `alarm` is not re-pulsed.
- admin_clear in IDLE or OPEN: clears fail_count only; an OPEN window is not cut short.
- relock outside OPEN: no effect.
- Latency: one cycle from the attempt edge to the unlocked/lockout/fail_count update.
- Mid-operation reset: rst during OPEN or LOCKOUT returns to IDLE in one cycle with all outputs zero.
- Invariants:
  - unlocked and lockout are never both high.
  - fail_count never exceeds MAX_FAIL and never wraps.

Test Plan:
1. rst 2 cycles; submit pulse with match=1 → unlocked rises the next cycle, stays high exactly 16 cycles, fail_count=0.
2. Three submit pulses with match=0 → fail_count 1, 2, then lockout=1 and alarm=1 for 1 cycle; lockout high 64 cycles; afterwards fail_count=0.
3. Two failures then one success → fail_count 1, 2, then 0, and unlocked asserts; no alarm.
4. submit held high 10 cycles with match=0 → fail_count=1 only. During LOCKOUT, submit with match=1 → no unlock.
5. OPEN, relock at cycle 5 → unlocked drops the next cycle. LOCKOUT, admin_clear at cycle 10 → lockout drops the next cycle, fail_count=0.
6. rst asserted mid-OPEN and mid-LOCKOUT → all outputs 0 the next cycle. submit held high through reset release → counted as one attempt.
